// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg
// Shared definitions for the multi-cycle integer divider.
//   - DIV_W_DEFAULT : default operand width
//   - div_state_e   : divider FSM state encoding
//   - RES_*_SLOT    : packing of the {HI, LO} result word, in DIV_W-sized slots
// Optional feature macro: DIV_BYZERO_FAST_EN (adds the BYZERO state).
// -----------------------------------------------------------------------------
package div_unit_pkg;

    localparam int DIV_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
`ifdef DIV_BYZERO_FAST_EN
        ST_BYZERO = 2'd1,
`endif
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } div_state_e;

    // LO (slot 0) carries the quotient, HI (slot 1) carries the remainder.
    localparam int RES_LO_SLOT = 0;
    localparam int RES_HI_SLOT = 1;

endpackage

// File: rtl/div_unit_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration on a 2*DIV_W+1 bit working
// register laid out as {partial remainder, remaining dividend / quotient}.
// Ports:
//   i_work    : working register before the step
//   i_divisor : divisor magnitude
//   o_work    : working register after shift, conditional subtract and
//               insertion of the new quotient bit at bit 0
// -----------------------------------------------------------------------------
module div_step #(
    parameter int DIV_W = 32
) (
    input  logic [2*DIV_W:0]  i_work,
    input  logic [DIV_W-1:0]  i_divisor,
    output logic [2*DIV_W:0]  o_work
);

    logic [DIV_W+1:0] w_upper;   // upper part after the 1-bit left shift, incl. the bit shifted out
    logic [DIV_W:0]   w_diff;
    logic             w_fit;     // no borrow: divisor fits, quotient bit is 1

    assign w_upper = i_work[2*DIV_W:DIV_W-1];
    assign w_fit   = (w_upper >= {2'b00, i_divisor});
    assign w_diff  = w_upper[DIV_W:0] - {1'b0, i_divisor};
    assign o_work  = {(w_fit ? w_diff : w_upper[DIV_W:0]), i_work[DIV_W-2:0], w_fit};

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Multi-cycle restoring divider for DIV/DIVU, one quotient bit per cycle.
// Ports:
//   clk, resetn          : clock, asynchronous active-low reset
//   start_i              : DIV/DIVU present in EX (held while stalled)
//   signed_div           : 1 = DIV, 0 = DIVU (sampled at acceptance)
//   opdata1_i/opdata2_i  : dividend / divisor
//   annul_i              : flush, aborts any division and clears the result
//   result_o             : {remainder, quotient} = {HI, LO}, registered
//   ready_o              : one-cycle result-valid pulse, registered
//   stall_o              : pipeline stall request (combinational)
// Optional feature macro: DIV_BYZERO_FAST_EN -- a zero divisor finishes via a
// one-cycle BYZERO state with a zero result instead of running all iterations.
// DIV_W must be at least 2.
// -----------------------------------------------------------------------------
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start_i,
    input  logic                 signed_div,
    input  logic [DIV_W-1:0]     opdata1_i,
    input  logic [DIV_W-1:0]     opdata2_i,
    input  logic                 annul_i,
    output logic [2*DIV_W-1:0]   result_o,
    output logic                 ready_o,
    output logic                 stall_o
);

    localparam int CNT_W = $clog2(DIV_W);

    div_state_e          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*DIV_W-1:0]  r_result;
    logic                r_ready;

    logic [2*DIV_W:0]    r_work;
    logic [DIV_W-1:0]    r_divisor;
    logic                r_sign1;
    logic                r_sign2;
    logic                r_signed;

    logic [2*DIV_W:0]    w_step_work;
    logic                w_accept;
    logic                w_last;
    logic [DIV_W-1:0]    w_mag1;
    logic [DIV_W-1:0]    w_mag2;
    logic [DIV_W-1:0]    w_quo;
    logic [DIV_W-1:0]    w_rem;
    logic [2*DIV_W-1:0]  w_packed;

    function automatic logic [DIV_W-1:0] neg_if(input logic [DIV_W-1:0] v, input logic neg);
        return neg ? (~v + DIV_W'(1)) : v;
    endfunction

    div_step #(
        .DIV_W     (DIV_W)
    ) u_step (
        .i_work    (r_work),
        .i_divisor (r_divisor),
        .o_work    (w_step_work)
    );

    assign w_accept = (r_state == ST_IDLE) && start_i && !annul_i;
    assign w_last   = (r_cnt == CNT_W'(DIV_W - 1));

    // Magnitudes: the most negative value maps onto itself, which is the
    // correct unsigned magnitude 2^(DIV_W-1).
    assign w_mag1 = neg_if(opdata1_i, signed_div & opdata1_i[DIV_W-1]);
    assign w_mag2 = neg_if(opdata2_i, signed_div & opdata2_i[DIV_W-1]);

    // Sign fix-up on the final step: quotient negative when signs differ,
    // remainder follows the dividend.
    assign w_quo = neg_if(w_step_work[DIV_W-1:0], r_signed & (r_sign1 ^ r_sign2));
    assign w_rem = neg_if(w_step_work[2*DIV_W-1:DIV_W], r_signed & r_sign1);

    always_comb begin
        w_packed = '0;
        w_packed[RES_LO_SLOT*DIV_W +: DIV_W] = w_quo;
        w_packed[RES_HI_SLOT*DIV_W +: DIV_W] = w_rem;
    end

    // Datapath registers: no reset needed, always loaded before use.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_work    <= {{(DIV_W+1){1'b0}}, w_mag1};
            r_divisor <= w_mag2;
            r_sign1   <= opdata1_i[DIV_W-1];
            r_sign2   <= opdata2_i[DIV_W-1];
            r_signed  <= signed_div;
        end else if (r_state == ST_ON) begin
            r_work    <= w_step_work;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_result <= '0;
            r_ready  <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            if (annul_i) begin
                r_state  <= ST_IDLE;
                r_result <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start_i) begin
                            r_cnt <= '0;
`ifdef DIV_BYZERO_FAST_EN
                            if (opdata2_i == '0) begin
                                r_state <= ST_BYZERO;
                            end else begin
                                r_state <= ST_ON;
                            end
`else
                            r_state <= ST_ON;
`endif
                        end
                    end
`ifdef DIV_BYZERO_FAST_EN
                    ST_BYZERO: begin
                        r_result <= '0;
                        r_ready  <= 1'b1;
                        r_state  <= ST_END;
                    end
`endif
                    ST_ON: begin
                        if (w_last) begin
                            r_result <= w_packed;
                            r_ready  <= 1'b1;
                            r_state  <= ST_END;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    // A start still seen here belongs to the completing instruction.
                    ST_END:  r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;
    assign stall_o  = start_i & ~annul_i & ~r_ready;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    localparam int W = 32;

    logic          clk        = 1'b0;
    logic          resetn     = 1'b0;
    logic          start_i    = 1'b0;
    logic          signed_div = 1'b0;
    logic          annul_i    = 1'b0;
    logic [W-1:0]  op1        = '0;
    logic [W-1:0]  op2        = '0;
    logic [2*W-1:0] result_o;
    logic          ready_o;
    logic          stall_o;

    int n_edge = 0;
    int n_vec  = 0;
    int n_err  = 0;

    typedef struct {
        logic [63:0] res;
        int          edge_no;
        string       name;
    } exp_t;

    exp_t sb[$];

    div_unit #(.DIV_W(W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start_i    (start_i),
        .signed_div (signed_div),
        .opdata1_i  (op1),
        .opdata2_i  (op2),
        .annul_i    (annul_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stall_o    (stall_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) n_edge <= n_edge + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // Monitor: every completion pulse must match the oldest expected entry,
    // both in value and in the edge at which it appears.
    always @(negedge clk) begin
        exp_t e;
        if (resetn && ready_o) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_ready: got result %h at edge %0d, required no completion",
                         result_o, n_edge);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_result"}, result_o, e.res);
                chk({e.name, "_latency"}, 64'(n_edge), 64'(e.edge_no));
            end
        end
    end

    // Drive a start; acc_dly = edges until the accepting edge, lat = cycles
    // from acceptance edge (cycle 0) to the ready cycle.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [63:0] res, input int lat, input int acc_dly,
                         input bit push, input string nm);
        exp_t e;
        op1        = a;
        op2        = b;
        signed_div = sgn;
        start_i    = 1'b1;
        if (push) begin
            e.res     = res;
            e.edge_no = n_edge + acc_dly + lat - 1;
            e.name    = nm;
            sb.push_back(e);
        end
        #1;
    endtask

    task automatic wait_ready(input int exp_stall, input string nm);
        int st = 0;
        int t  = 0;
        while (ready_o !== 1'b1 && t < 200) begin
            if (stall_o === 1'b1) st++;
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 200) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got no ready_o in %0d cycles, required a completion", nm, t);
        end
        chk({nm, "_stall_cycles"}, 64'(st), 64'(exp_stall));
        chk({nm, "_stall_in_end"}, 64'(stall_o), 64'(0));
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       input logic [63:0] res, input int lat, input string nm);
        @(negedge clk);
        issue(a, b, sgn, res, lat, 1, 1'b1, nm);
        wait_ready(lat, nm);
        start_i = 1'b0;
    endtask

    task automatic quiet(input int n, input string nm);
        repeat (n) @(negedge clk);
        #1;
        chk({nm, "_ready_low"}, 64'(ready_o), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] z_u_res, z_s_res;
        int          z_lat;
`ifdef DIV_BYZERO_FAST_EN
        z_u_res = 64'h0;
        z_s_res = 64'h0;
        z_lat   = 2;
`else
        z_u_res = {32'h0000_0005, 32'hFFFF_FFFF};
        z_s_res = {32'hFFFF_FFF8, 32'h0000_0001};
        z_lat   = 33;
`endif

        // Reset values
        #1;
        chk("reset_result", result_o, 64'h0);
        chk("reset_ready", 64'(ready_o), 64'(0));
        chk("reset_stall", 64'(stall_o), 64'(0));
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        run(32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, 33, "divu_100_7");
        repeat (3) @(negedge clk);
        #1;
        chk("hold_in_idle", result_o, {32'h2, 32'hE});

        run(32'hFFFF_FFF9, 32'd2,          1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, "div_m7_2");
        run(32'd7,         32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 33, "div_7_m2");
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0000_0000, 32'h8000_0000}, 33, "div_ovf");
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'h0000_0000}, 33, "divu_big");
        run(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, {32'hFFFF_FFFE, 32'h0000_000E}, 33, "div_m100_m7");
        run(32'hFFFF_FFFF, 32'd1,          1'b0, {32'h0000_0000, 32'hFFFF_FFFF}, 33, "divu_max_1");
        run(32'd5,         32'd0,          1'b0, z_u_res, z_lat, "divu_5_0");
        run(32'hFFFF_FFF8, 32'd0,          1'b1, z_s_res, z_lat, "div_m8_0");

        // Annul at cycle 10 of a division
        run(32'd50, 32'd5, 1'b0, {32'h0, 32'd10}, 33, "divu_50_5");
        @(negedge clk);
        issue(32'd1000, 32'd3, 1'b0, 64'h0, 33, 1, 1'b0, "annul");
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        #1;
        chk("annul_stall_masked", 64'(stall_o), 64'(0));
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        #1;
        chk("annul_result_cleared", result_o, 64'h0);
        chk("annul_ready_low", 64'(ready_o), 64'(0));
        quiet(40, "annul_no_completion");
        run(32'd9, 32'd3, 1'b0, {32'h0, 32'h3}, 33, "divu_9_3");

        // Reset asserted at cycle 20 of a division
        @(negedge clk);
        issue(32'd77, 32'd5, 1'b0, 64'h0, 33, 1, 1'b0, "rst");
        repeat (20) @(negedge clk);
        resetn  = 1'b0;
        start_i = 1'b0;
        #1;
        chk("midreset_result", result_o, 64'h0);
        chk("midreset_ready", 64'(ready_o), 64'(0));
        chk("midreset_stall", 64'(stall_o), 64'(0));
        @(negedge clk);
        resetn = 1'b1;
        quiet(40, "midreset_no_completion");

        // Back-to-back: second start held through END, accepted in the next IDLE cycle
        @(negedge clk);
        issue(32'd1000, 32'd10, 1'b0, {32'h0, 32'd100}, 33, 1, 1'b1, "b2b_first");
        wait_ready(33, "b2b_first");
        issue(32'hFFFF_FFFF, 32'd16, 1'b0, {32'h0000_000F, 32'h0FFF_FFFF}, 33, 2, 1'b1, "b2b_second");
        @(negedge clk);
        #1;
        wait_ready(33, "b2b_second");
        start_i = 1'b0;

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
